// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin scratch-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_DEF = 15;
  localparam int WCNT_W      = $clog2(TIMEOUT_DEF + 1);

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signal bundle of the arbiter.
interface mem_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_wr_rd;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]      req_wdata;
  logic [NREQ-1:0]            req_ready;
  logic                       req_err;
  logic [WIDTH-1:0]           req_rdata;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       busy;
  logic                       mem_valid;
  logic                       mem_wr_rd;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [WIDTH-1:0]           mem_wdata;
  logic                       mem_ready;
  logic [WIDTH-1:0]           mem_rdata;

  // Arbiter side.
  modport slave (
    input  req_valid, req_wr_rd, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, req_err, req_rdata, gnt_idx, busy,
           mem_valid, mem_wr_rd, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output req_valid, req_wr_rd, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, req_err, req_rdata, gnt_idx, busy,
           mem_valid, mem_wr_rd, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mem_arb_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  cand [NREQ];

  assign dbl = {req, req};
  assign rot = dbl[ptr +: NREQ];

  // cand[gi] is the real requester index behind rotated position gi.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ))
                                                 : sum[IDX_W-1:0];
  end

  always_comb begin
    any = |rot;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one single-port memory,
// with a per-transaction ready timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0]       ready_q, ready_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  mvalid_q, mvalid_d;
  logic                  busy_q, busy_d;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_idx;
  logic [ADDR_WIDTH-1:0] req_addr_a  [NREQ];
  logic [WIDTH-1:0]      req_wdata_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_addr_a[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_wdata_a[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
  end

  mem_arb_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          wr_d    = bus.req_wr_rd[pick_idx];
          addr_d  = req_addr_a[pick_idx];
          wdata_d = req_wdata_a[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_ready) begin
          if (!wr_q) rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    mvalid_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
    ready_d  = '0;
    if (state_d == RESP) ready_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mvalid_q <= mvalid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.req_err   = err_q;
  assign bus.req_rdata = rdata_q;
  assign bus.gnt_idx   = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.mem_valid = mvalid_q;
  assign bus.mem_wr_rd = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
